// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared types and default geometry for the L2 cache
package l2_types;

  localparam int OFFSET      = 5;
  localparam int DEF_S_INDEX = 3;
  localparam int TAG_W       = 32 - OFFSET - DEF_S_INDEX;
  localparam int SETS        = 2 ** DEF_S_INDEX;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } l2_state_t;

endpackage

// File: rtl/l2_cache_if.sv
// rtl/l2_cache_if.sv - whole-line request/response bus, used upstream and toward memory
interface l2_cache_if #(
  parameter int WIDTH = 256
);

  logic             read;
  logic             write;
  logic [31:0]      address;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);

endinterface

// File: rtl/l2_cache_array.sv
// rtl/l2_cache_array.sv - per-set flop storage, combinational read, optional async clear
module l2_array #(
  parameter int width   = 1,
  parameter int S_INDEX = 3,
  parameter bit CLEAR   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [S_INDEX-1:0] idx_i,
  input  logic [width-1:0]   wdata_i,
  output logic [width-1:0]   rdata_o
);

  logic [width-1:0] mem_q [2**S_INDEX];

  generate
    if (CLEAR) begin : g_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 2**S_INDEX; i++) mem_q[i] <= '0;
        end else if (we_i) begin
          mem_q[idx_i] <= wdata_i;
        end
      end
    end else begin : g_noclr
      // Contents survive reset; validity is tracked by a separately cleared array.
      logic unused_rst;
      assign unused_rst = rst;
      always_ff @(posedge clk) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
      end
    end
  endgenerate

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/l2_cache.sv
// rtl/l2_cache.sv - 2-way write-back, write-allocate L2 serving whole 32-byte lines
module l2_cache
  import l2_types::*;
#(
  parameter int S_INDEX = DEF_S_INDEX,
  parameter int WIDTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  l2_cache_if.slave   l2,
  l2_cache_if.master  pmem
);

  localparam int TAG_BITS = 32 - OFFSET - S_INDEX;

  l2_state_t            state_q;
  logic [TAG_BITS-1:0]  miss_tag_q;
  logic [S_INDEX-1:0]   miss_idx_q;
  logic                 victim_q;

  logic [TAG_BITS-1:0]  req_tag;
  logic [S_INDEX-1:0]   req_idx;
  logic [S_INDEX-1:0]   idx;
  logic                 req;
  logic                 is_write;
  logic                 unused_addr_lsb;

  logic [WIDTH-1:0]     data_r [2];
  logic [TAG_BITS-1:0]  tag_r  [2];
  logic [1:0]           valid_r;
  logic [1:0]           dirty_r;
  logic                 lru_r;

  logic [1:0]           data_we, tag_we, valid_we, dirty_we;
  logic                 lru_we;
  logic [WIDTH-1:0]     data_wd;
  logic                 dirty_wd;

  logic [1:0]           hit_w;
  logic                 hit;
  logic                 hit_way;
  logic                 victim;
  logic                 fill;

  assign req_tag         = l2.address[31:OFFSET+S_INDEX];
  assign req_idx         = l2.address[OFFSET+S_INDEX-1:OFFSET];
  assign unused_addr_lsb = ^l2.address[OFFSET-1:0];
  assign req             = l2.read | l2.write;
  assign is_write        = l2.write;

  // Outside CHECK the upstream address may have moved on, so use the latched miss set.
  assign idx = (state_q == CHECK) ? req_idx : miss_idx_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    l2_array #(.width(WIDTH), .S_INDEX(S_INDEX), .CLEAR(1'b0)) u_data (
      .clk(clk), .rst(rst), .we_i(data_we[w]), .idx_i(idx),
      .wdata_i(data_wd), .rdata_o(data_r[w]));
    l2_array #(.width(TAG_BITS), .S_INDEX(S_INDEX), .CLEAR(1'b0)) u_tag (
      .clk(clk), .rst(rst), .we_i(tag_we[w]), .idx_i(idx),
      .wdata_i(miss_tag_q), .rdata_o(tag_r[w]));
    l2_array #(.width(1), .S_INDEX(S_INDEX), .CLEAR(1'b1)) u_valid (
      .clk(clk), .rst(rst), .we_i(valid_we[w]), .idx_i(idx),
      .wdata_i(1'b1), .rdata_o(valid_r[w]));
    l2_array #(.width(1), .S_INDEX(S_INDEX), .CLEAR(1'b1)) u_dirty (
      .clk(clk), .rst(rst), .we_i(dirty_we[w]), .idx_i(idx),
      .wdata_i(dirty_wd), .rdata_o(dirty_r[w]));
    assign hit_w[w] = valid_r[w] && (tag_r[w] == req_tag);
  end

  l2_array #(.width(1), .S_INDEX(S_INDEX), .CLEAR(1'b1)) u_lru (
    .clk(clk), .rst(rst), .we_i(lru_we), .idx_i(idx),
    .wdata_i(~hit_way), .rdata_o(lru_r));

  assign hit     = req && (state_q == CHECK) && (|hit_w);
  assign hit_way = ~hit_w[0];
  assign victim  = !valid_r[0] ? 1'b0 : (!valid_r[1] ? 1'b1 : lru_r);
  assign fill    = (state_q == ALLOCATE) && pmem.resp;

  always_comb begin
    data_we  = '0;
    tag_we   = '0;
    valid_we = '0;
    dirty_we = '0;
    lru_we   = 1'b0;
    data_wd  = (state_q == ALLOCATE) ? pmem.rdata : l2.wdata;
    dirty_wd = (state_q == CHECK);
    if (hit) begin
      lru_we = 1'b1;
      if (is_write) begin
        data_we[hit_way]  = 1'b1;
        dirty_we[hit_way] = 1'b1;
      end
    end
    if (fill) begin
      data_we[victim_q]  = 1'b1;
      tag_we[victim_q]   = 1'b1;
      valid_we[victim_q] = 1'b1;
      dirty_we[victim_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CHECK;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= 1'b0;
    end else begin
      case (state_q)
        CHECK: begin
          if (req && !(|hit_w)) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            victim_q   <= victim;
            state_q    <= (valid_r[victim] && dirty_r[victim]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (pmem.resp) state_q <= ALLOCATE;
        ALLOCATE:  if (pmem.resp) state_q <= CHECK;
        default:   state_q <= CHECK;
      endcase
    end
  end

  assign l2.resp    = hit;
  assign l2.rdata   = hit ? data_r[hit_way] : '0;
  assign pmem.read  = (state_q == ALLOCATE);
  assign pmem.write = (state_q == WRITEBACK);
  assign pmem.wdata = (state_q == WRITEBACK) ? data_r[victim_q] : '0;

  always_comb begin
    pmem.address = '0;
    if (state_q == WRITEBACK) pmem.address = {tag_r[victim_q], miss_idx_q, {OFFSET{1'b0}}};
    if (state_q == ALLOCATE)  pmem.address = {miss_tag_q, miss_idx_q, {OFFSET{1'b0}}};
  end

  a_no_read_write: assert property (@(posedge clk) disable iff (rst) !(l2.read && l2.write));

endmodule

// File: tb/tb_l2_cache.sv
// tb/tb_l2_cache.sv - directed self-checking bench for l2_cache
module tb_l2_cache;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [255:0] PAT_A = {8{32'hAAAA_0040}};
  localparam logic [255:0] PAT_B = {8{32'hBBBB_1111}};
  localparam logic [255:0] PAT_C = {8{32'hCCCC_0140}};
  localparam logic [255:0] PAT_D = {8{32'hDDDD_0240}};
  localparam logic [255:0] PAT_E = {8{32'hEEEE_0340}};
  localparam logic [255:0] PAT_F = {8{32'hF0F0_2402}};
  localparam logic [255:0] PAT_G = {8{32'h6666_0060}};
  localparam logic [255:0] PAT_H = {8{32'h8888_0080}};
  localparam logic [255:0] PAT_J = {8{32'h1234_5678}};

  always #5 clk = ~clk;

  l2_cache_if #(.WIDTH(256)) up ();
  l2_cache_if #(.WIDTH(256)) mem ();

  l2_cache #(.S_INDEX(3), .WIDTH(256)) dut (
    .clk  (clk),
    .rst  (rst),
    .l2   (up),
    .pmem (mem)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] wd);
    up.read    = rd;
    up.write   = wr;
    up.address = a;
    up.wdata   = wd;
  endtask

  task automatic idle();
    up.read  = 1'b0;
    up.write = 1'b0;
  endtask

  task automatic wait_pmem(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [255:0] exp_wd);
    int n = 0;
    #1;
    while (!(mem.read || mem.write) && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_read"}, mem.read, !exp_wr);
    chk({tag, "_write"}, mem.write, exp_wr);
    chk({tag, "_addr"}, mem.address, exp_addr);
    if (exp_wr) chk({tag, "_wdata"}, mem.wdata, exp_wd);
  endtask

  task automatic mem_respond(input int lat, input logic [255:0] rd);
    repeat (lat) step();
    mem.rdata = rd;
    mem.resp  = 1'b1;
    step();
    mem.resp  = 1'b0;
    mem.rdata = '0;
  endtask

  task automatic wait_resp(input string tag, input logic chk_rd, input logic [255:0] exp_rd);
    int n = 0;
    #1;
    while (!up.resp && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_resp"}, up.resp, 1'b1);
    chk({tag, "_lat"}, n, 0);
    if (chk_rd) chk({tag, "_rdata"}, up.rdata, exp_rd);
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    up.read    = 1'b0;
    up.write   = 1'b0;
    up.address = '0;
    up.wdata   = '0;
    mem.resp   = 1'b0;
    mem.rdata  = '0;
    #2 rst = 1'b1;
    repeat (2) step();
    chk("rst_l2_resp", up.resp, 1'b0);
    chk("rst_l2_rdata", up.rdata, '0);
    chk("rst_pmem_read", mem.read, 1'b0);
    chk("rst_pmem_write", mem.write, 1'b0);
    chk("rst_pmem_addr", mem.address, '0);
    chk("rst_pmem_wdata", mem.wdata, '0);
    step();
    rst = 1'b0;

    // Cold miss on 0x40, then a same-cycle hit, then a write hit that dirties way0.
    req(1'b1, 1'b0, 32'h40, '0);
    wait_pmem("fill40", 1'b0, 32'h40, '0);
    mem_respond(5, PAT_A);
    wait_resp("rd40", 1'b1, PAT_A);

    req(1'b1, 1'b0, 32'h40, '0);
    #1;
    chk("hit40_no_pmem_read", mem.read, 1'b0);
    chk("hit40_no_pmem_write", mem.write, 1'b0);
    wait_resp("hit40", 1'b1, PAT_A);

    req(1'b0, 1'b1, 32'h40, PAT_B);
    wait_resp("wr40", 1'b0, '0);

    req(1'b1, 1'b0, 32'h140, '0);
    wait_pmem("fill140", 1'b0, 32'h140, '0);
    mem_respond(3, PAT_C);
    wait_resp("rd140", 1'b1, PAT_C);

    // Dirty eviction of 0x40 (LRU way0) before filling 0x240.
    req(1'b1, 1'b0, 32'h240, '0);
    wait_pmem("wb40", 1'b1, 32'h40, PAT_B);
    mem_respond(4, '0);
    wait_pmem("fill240", 1'b0, 32'h240, '0);
    mem_respond(2, PAT_D);
    wait_resp("rd240", 1'b1, PAT_D);

    // Clean eviction of 0x140: straight to a fill.
    req(1'b1, 1'b0, 32'h340, '0);
    wait_pmem("fill340", 1'b0, 32'h340, '0);
    mem_respond(2, PAT_E);
    wait_resp("rd340", 1'b1, PAT_E);

    req(1'b0, 1'b1, 32'h240, PAT_F);
    wait_resp("wr240", 1'b0, '0);
    req(1'b1, 1'b0, 32'h340, '0);
    wait_resp("hit340", 1'b1, PAT_E);

    // Reset in the middle of a writeback.
    req(1'b1, 1'b0, 32'h40, '0);
    wait_pmem("wb240", 1'b1, 32'h240, PAT_F);
    rst = 1'b1;
    idle();
    #1;
    chk("rst_mid_pmem_write", mem.write, 1'b0);
    chk("rst_mid_pmem_addr", mem.address, '0);
    step();
    rst = 1'b0;

    // Valid bits were cleared, so 0x240 misses; memory stalls for 20 cycles.
    req(1'b1, 1'b0, 32'h240, '0);
    wait_pmem("refill240", 1'b0, 32'h240, '0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_l2_resp", up.resp, 1'b0);
      chk("stall_pmem_addr", mem.address, 32'h240);
    end
    mem_respond(0, PAT_J);
    wait_resp("rd240b", 1'b1, PAT_J);

    req(1'b1, 1'b0, 32'h60, '0);
    wait_pmem("fill60", 1'b0, 32'h60, '0);
    mem_respond(1, PAT_G);
    wait_resp("rd60", 1'b1, PAT_G);

    // Back-to-back hits on different sets.
    req(1'b1, 1'b0, 32'h240, '0);
    wait_resp("b2b240", 1'b1, PAT_J);
    req(1'b1, 1'b0, 32'h60, '0);
    wait_resp("b2b60", 1'b1, PAT_G);

    // Request abandoned mid-fill: line still installed, no response.
    req(1'b1, 1'b0, 32'h80, '0);
    wait_pmem("fill80", 1'b0, 32'h80, '0);
    idle();
    mem_respond(3, PAT_H);
    #1;
    chk("drop80_no_resp", up.resp, 1'b0);
    step();
    req(1'b1, 1'b0, 32'h80, '0);
    #1;
    chk("hit80_no_pmem_read", mem.read, 1'b0);
    wait_resp("hit80", 1'b1, PAT_H);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
